// File: rtl/instr_fetch_unit_pkg.sv
// Shared CPU front-end constants: word/address widths, fetch FSM encoding and
// the prefetch buffer entry layout.
package instr_fetch_unit_pkg;

  localparam int unsigned DataW = 16;
  localparam int unsigned AddrW = 16;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StReq   = 2'd1,
    StDrain = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [AddrW-1:0] pc;
    logic [DataW-1:0] data;
  } fetch_entry_t;

  // Word-address increment, wraps 0xFFFF -> 0x0000.
  function automatic logic [AddrW-1:0] pc_inc(input logic [AddrW-1:0] pc);
    return pc + AddrW'(1);
  endfunction

endpackage

// File: rtl/instr_fetch_unit_fetch_buffer.sv
// Prefetch FIFO of {pc, data} pairs with synchronous flush; head is registered
// storage so there is no combinational path from memory to the IR.
module instr_fetch_unit_fetch_buffer
  import instr_fetch_unit_pkg::*;
#(
  parameter int unsigned Depth = 2
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic                   flush_i,
  input  logic                   push_i,
  input  logic [AddrW-1:0]       push_pc_i,
  input  logic [DataW-1:0]       push_data_i,
  input  logic                   pop_i,
  output logic [$clog2(Depth):0] count_o,
  output logic [AddrW-1:0]       head_pc_o,
  output logic [DataW-1:0]       head_data_o
);

  localparam int unsigned PtrW = $clog2(Depth);

  fetch_entry_t           mem_q [Depth];
  logic [PtrW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [PtrW:0]          count_q, count_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_i) wr_ptr_d = wr_ptr_q + PtrW'(1);
      if (pop_i)  rd_ptr_d = rd_ptr_q + PtrW'(1);
      case ({push_i, pop_i})
        2'b10:   count_d = count_q + (PtrW+1)'(1);
        2'b01:   count_d = count_q - (PtrW+1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < Depth; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (push_i && !flush_i) mem_q[wr_ptr_q] <= '{pc: push_pc_i, data: push_data_i};
    end
  end

  assign count_o     = count_q;
  assign head_pc_o   = mem_q[rd_ptr_q].pc;
  assign head_data_o = mem_q[rd_ptr_q].data;

endmodule

// File: rtl/instr_fetch_unit.sv
// CPU instruction fetch front end: PC walker and single-outstanding memory
// request FSM feeding a prefetch buffer, with redirect flush and drain.
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter int unsigned     Depth   = 2,
  parameter logic [AddrW-1:0] ResetPc = '0
) (
  input  logic             clk_i,
  input  logic             reset_i,
  output logic             mem_req_o,
  output logic [AddrW-1:0] mem_addr_o,
  input  logic             mem_ack_i,
  input  logic [DataW-1:0] mem_rdata_i,
  output logic             ir_valid_o,
  output logic [DataW-1:0] ir_data_o,
  output logic [AddrW-1:0] ir_pc_o,
  input  logic             ir_load_i,
  input  logic             redirect_i,
  input  logic [AddrW-1:0] redirect_pc_i
);

  localparam int unsigned   CntW     = $clog2(Depth) + 1;
  localparam logic [CntW-1:0] DepthCnt = CntW'(Depth);
  localparam logic [CntW-1:0] DepthM1  = CntW'(Depth - 1);

  fetch_state_e     state_q, state_d;
  logic [AddrW-1:0] fetch_pc_q, fetch_pc_d;
  logic [AddrW-1:0] drain_addr_q, drain_addr_d;
  logic [CntW-1:0]  count;
  logic             push, pop, flush;

  // Redirect wins over any same-cycle IR pop.
  assign pop = ir_valid_o && ir_load_i && !redirect_i;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q      <= StIdle;
      fetch_pc_q   <= ResetPc;
      drain_addr_q <= ResetPc;
    end else begin
      state_q      <= state_d;
      fetch_pc_q   <= fetch_pc_d;
      drain_addr_q <= drain_addr_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    fetch_pc_d   = fetch_pc_q;
    drain_addr_d = drain_addr_q;
    push         = 1'b0;
    flush        = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (redirect_i) begin
          flush      = 1'b1;
          fetch_pc_d = redirect_pc_i;
          state_d    = StReq;
        end else if ((count != DepthCnt) || pop) begin
          state_d = StReq;
        end
      end
      StReq: begin
        if (redirect_i) begin
          flush      = 1'b1;
          fetch_pc_d = redirect_pc_i;
          if (mem_ack_i) begin
            state_d = StReq;
          end else begin
            // Bus must keep the old address until the pending ack arrives.
            drain_addr_d = fetch_pc_q;
            state_d      = StDrain;
          end
        end else if (mem_ack_i) begin
          push       = 1'b1;
          fetch_pc_d = pc_inc(fetch_pc_q);
          state_d    = (pop || (count != DepthM1)) ? StReq : StIdle;
        end
      end
      StDrain: begin
        if (redirect_i) begin
          flush      = 1'b1;
          fetch_pc_d = redirect_pc_i;
        end
        if (mem_ack_i) state_d = StReq;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    mem_req_o  = (state_q == StReq) || (state_q == StDrain);
    mem_addr_o = (state_q == StDrain) ? drain_addr_q : fetch_pc_q;
    ir_valid_o = (count != '0);
  end

  instr_fetch_unit_fetch_buffer #(
    .Depth (Depth)
  ) u_fetch_buffer (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .flush_i     (flush),
    .push_i      (push),
    .push_pc_i   (fetch_pc_q),
    .push_data_i (mem_rdata_i),
    .pop_i       (pop),
    .count_o     (count),
    .head_pc_o   (ir_pc_o),
    .head_data_o (ir_data_o)
  );

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: zero-wait streaming, backpressure,
// redirect drain/collision, PC wrap and reset mid-transaction.
module tb_instr_fetch_unit;
  import instr_fetch_unit_pkg::*;

  logic             clk = 1'b0;
  logic             reset;
  logic             mem_req;
  logic [AddrW-1:0] mem_addr;
  logic             mem_ack;
  logic [DataW-1:0] mem_rdata;
  logic             ir_valid;
  logic [DataW-1:0] ir_data;
  logic [AddrW-1:0] ir_pc;
  logic             ir_load;
  logic             redirect;
  logic [AddrW-1:0] redirect_pc;

  logic             zw_en;
  logic             man_ack;
  logic [DataW-1:0] man_rdata;

  int unsigned n_checks = 0;
  int unsigned n_fails  = 0;

  always #5 clk = ~clk;

  function automatic logic [DataW-1:0] mem_word(input logic [AddrW-1:0] a);
    return a ^ 16'hA5A5;
  endfunction

  assign mem_ack   = zw_en ? mem_req : man_ack;
  assign mem_rdata = zw_en ? mem_word(mem_addr) : man_rdata;

  instr_fetch_unit #(
    .Depth   (2),
    .ResetPc (16'h0000)
  ) dut (
    .clk_i         (clk),
    .reset_i       (reset),
    .mem_req_o     (mem_req),
    .mem_addr_o    (mem_addr),
    .mem_ack_i     (mem_ack),
    .mem_rdata_i   (mem_rdata),
    .ir_valid_o    (ir_valid),
    .ir_data_o     (ir_data),
    .ir_pc_o       (ir_pc),
    .ir_load_i     (ir_load),
    .redirect_i    (redirect),
    .redirect_pc_i (redirect_pc)
  );

  task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic apply_reset();
    reset   = 1'b1;
    man_ack = 1'b0;
    redirect = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  // Manual memory: hold the request for delay cycles, ack on the last one.
  task automatic serve(input logic [AddrW-1:0] a, input int delay);
    for (int i = 0; i < delay; i++) begin
      check_value("serve_req", 32'(mem_req), 32'h1);
      check_value("serve_addr", 32'(mem_addr), 32'(a));
      if (i == delay - 1) begin
        man_ack   = 1'b1;
        man_rdata = mem_word(a);
      end
      @(negedge clk);
    end
    man_ack = 1'b0;
  endtask

  initial begin
    reset       = 1'b1;
    zw_en       = 1'b0;
    man_ack     = 1'b0;
    man_rdata   = '0;
    ir_load     = 1'b0;
    redirect    = 1'b0;
    redirect_pc = '0;
    repeat (2) @(negedge clk);
    check_value("rst_req", 32'(mem_req), 32'h0);
    check_value("rst_addr", 32'(mem_addr), 32'h0);
    check_value("rst_valid", 32'(ir_valid), 32'h0);
    check_value("rst_data", 32'(ir_data), 32'h0);
    check_value("rst_pc", 32'(ir_pc), 32'h0);

    // Zero-wait streaming, one word per cycle.
    zw_en   = 1'b1;
    ir_load = 1'b1;
    reset   = 1'b0;
    @(negedge clk);
    check_value("t1_req", 32'(mem_req), 32'h1);
    check_value("t1_valid0", 32'(ir_valid), 32'h0);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check_value("t1_valid", 32'(ir_valid), 32'h1);
      check_value("t1_pc", 32'(ir_pc), 32'(k));
      check_value("t1_data", 32'(ir_data), 32'(mem_word(16'(k))));
    end

    // Backpressure: buffer fills, request stops, one pop restarts it.
    ir_load = 1'b0;
    apply_reset();
    repeat (2) @(negedge clk);
    check_value("t2_pc0", 32'(ir_pc), 32'h0);
    check_value("t2_addr1", 32'(mem_addr), 32'h1);
    @(negedge clk);
    check_value("t2_req_full", 32'(mem_req), 32'h0);
    check_value("t2_data_held", 32'(ir_data), 32'(mem_word(16'h0)));
    @(negedge clk);
    check_value("t2_req_full2", 32'(mem_req), 32'h0);
    ir_load = 1'b1;
    @(negedge clk);
    ir_load = 1'b0;
    check_value("t2_pc1", 32'(ir_pc), 32'h1);
    check_value("t2_req_resume", 32'(mem_req), 32'h1);
    check_value("t2_addr2", 32'(mem_addr), 32'h2);

    // Redirect while a slow request is outstanding.
    zw_en   = 1'b0;
    ir_load = 1'b1;
    apply_reset();
    @(negedge clk);
    serve(16'h0000, 3);
    serve(16'h0001, 3);
    serve(16'h0002, 3);
    check_value("t3_pc2", 32'(ir_pc), 32'h2);
    redirect    = 1'b1;
    redirect_pc = 16'h0040;
    @(negedge clk);
    redirect = 1'b0;
    check_value("t3_flush", 32'(ir_valid), 32'h0);
    check_value("t3_drain_req", 32'(mem_req), 32'h1);
    check_value("t3_drain_addr", 32'(mem_addr), 32'h3);
    @(negedge clk);
    check_value("t3_drain_addr2", 32'(mem_addr), 32'h3);
    man_ack   = 1'b1;
    man_rdata = 16'hDEAD;
    @(negedge clk);
    man_ack = 1'b0;
    check_value("t3_discard", 32'(ir_valid), 32'h0);
    check_value("t3_new_addr", 32'(mem_addr), 32'h40);
    serve(16'h0040, 1);
    check_value("t3_valid", 32'(ir_valid), 32'h1);
    check_value("t3_pc40", 32'(ir_pc), 32'h40);
    check_value("t3_data40", 32'(ir_data), 32'(mem_word(16'h0040)));

    // Redirect, ack and load all in one cycle.
    zw_en   = 1'b1;
    ir_load = 1'b1;
    apply_reset();
    repeat (2) @(negedge clk);
    check_value("t4_pc0", 32'(ir_pc), 32'h0);
    check_value("t4_addr1", 32'(mem_addr), 32'h1);
    redirect    = 1'b1;
    redirect_pc = 16'h0123;
    @(negedge clk);
    redirect = 1'b0;
    check_value("t4_flush", 32'(ir_valid), 32'h0);
    check_value("t4_addr", 32'(mem_addr), 32'h123);
    @(negedge clk);
    check_value("t4_pc", 32'(ir_pc), 32'h123);
    check_value("t4_data", 32'(ir_data), 32'(mem_word(16'h0123)));

    // PC wrap at the top of the address space.
    redirect    = 1'b1;
    redirect_pc = 16'hFFFF;
    @(negedge clk);
    redirect = 1'b0;
    check_value("t5_addr", 32'(mem_addr), 32'hFFFF);
    check_value("t5_flush", 32'(ir_valid), 32'h0);
    @(negedge clk);
    check_value("t5_pc_ffff", 32'(ir_pc), 32'hFFFF);
    check_value("t5_data_ffff", 32'(ir_data), 32'h5A5A);
    @(negedge clk);
    check_value("t5_pc_wrap", 32'(ir_pc), 32'h0);
    check_value("t5_data_wrap", 32'(ir_data), 32'hA5A5);

    // Reset while a request waits for its ack; the late ack is ignored.
    zw_en   = 1'b0;
    ir_load = 1'b0;
    apply_reset();
    @(negedge clk);
    check_value("t6_req", 32'(mem_req), 32'h1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_value("t6_req_drop", 32'(mem_req), 32'h0);
    check_value("t6_valid", 32'(ir_valid), 32'h0);
    man_ack   = 1'b1;
    man_rdata = 16'hBEEF;
    reset     = 1'b0;
    @(negedge clk);
    man_ack = 1'b0;
    check_value("t6_late_ack", 32'(ir_valid), 32'h0);
    check_value("t6_restart_addr", 32'(mem_addr), 32'h0);
    serve(16'h0000, 1);
    check_value("t6_pc", 32'(ir_pc), 32'h0);
    check_value("t6_data", 32'(ir_data), 32'hA5A5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
